// File: rtl/uart_rx_ctrl_pkg.sv
// Shared register map, bit positions and reset constants for the UART receive controller.
package uart_rx_ctrl_pkg;

    localparam logic [2:0] OFF_RBR     = 3'd0;
    localparam logic [2:0] OFF_CTRL    = 3'd1;
    localparam logic [2:0] OFF_DIV     = 3'd2;
    localparam logic [2:0] OFF_THRESH  = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;
    localparam logic [2:0] OFF_TIMEOUT = 3'd5;

    localparam int CTRL_FLUSH = 7;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_PERR  = 3;
    localparam int ST_TO    = 4;
    localparam int ST_BUSY  = 5;
    localparam int ST_LEVEL = 8;

    // Field order matches CTRL[6:0], so a raw write casts straight in.
    typedef struct packed {
        logic       to_en;
        logic       err_en;
        logic       rxne_en;
        logic [1:0] bits;
        logic       parity_en;
        logic       en;
    } ctrl_t;

    localparam ctrl_t       CTRL_RST    = 7'h0C;
    localparam logic [15:0] DIV_RST     = 16'h01B1;
    localparam int          THRESH_RST  = 1;
    localparam logic [7:0]  TIMEOUT_RST = 8'h28;

endpackage

// File: rtl/uart_rx_fifo.sv
// Character FIFO; pointers carry a wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot a same-cycle push needs when full.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/apb_uart_rx_ctrl.sv
// APB register front end for the UART receiver: configuration, RX FIFO drain,
// overrun/parity/idle-timeout tracking and a registered level interrupt.
module apb_uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [31:0]               pwdata,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      cfg_en_o,
    output logic                      cfg_parity_en_o,
    output logic [1:0]                cfg_bits_o,
    output logic [15:0]               cfg_div_o,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      rx_ready_o,
    input  logic                      rx_busy_i,
    input  logic                      rx_err_i,
    output logic                      rx_err_clr_o,
    output logic                      irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    ctrl_t          ctrl_q;
    logic [15:0]    div_q;
    logic [LW-1:0]  thresh_q;
    logic [7:0]     tmo_q;
    logic           overrun_q, overrun_d;
    logic           timeout_q, timeout_d;
    logic           irq_q, irq_d;
    logic           err_clr_q, err_clr_d;
    logic [15:0]    presc_q, presc_d;
    logic [7:0]     idle_q, idle_d;

    logic [2:0]     off;
    logic           access, wr_en, rd_en, mapped, st_wr;
    logic           pop, flush, push_req, ovr_set, to_set, idle_clr;
    logic [7:0]     fifo_data;
    logic           fifo_full, fifo_empty;
    logic [LW-1:0]  fifo_level, thresh_eff;
    logic [31:0]    rdata;
    logic           unused_bits;

    assign unused_bits = ^{paddr[APB_ADDR_WIDTH-1:5], paddr[1:0], pwdata[31:16]};

    assign off      = paddr[4:2];
    assign access   = psel & penable;
    assign wr_en    = access & pwrite;
    assign rd_en    = access & ~pwrite;
    assign mapped   = (off <= OFF_TIMEOUT);
    assign st_wr    = wr_en & (off == OFF_STATUS);
    assign pop      = rd_en & (off == OFF_RBR);
    assign flush    = wr_en & (off == OFF_CTRL) & pwdata[CTRL_FLUSH];
    assign push_req = rx_valid_i & ctrl_q.en;
    // Flush silently discards a colliding character; a pop makes room when full.
    assign ovr_set  = push_req & fifo_full & ~pop & ~flush;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push_req),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (rx_data_i),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign idle_clr = push_req | pop | flush | fifo_empty | rx_busy_i;

    // Prescaler spans DIV+1 clocks per bit-time; idle count holds once it hits the limit.
    always_comb begin
        presc_d = presc_q;
        idle_d  = idle_q;
        to_set  = 1'b0;
        if (idle_clr) begin
            presc_d = '0;
            idle_d  = '0;
        end else if (tmo_q != 8'd0 && idle_q < tmo_q) begin
            if (presc_q >= div_q) begin
                presc_d = '0;
                idle_d  = idle_q + 8'd1;
                to_set  = (idle_q + 8'd1 == tmo_q);
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    assign thresh_eff = (thresh_q == '0) ? LW'(1) : thresh_q;
    assign overrun_d  = ovr_set | (overrun_q & ~(st_wr & pwdata[ST_OVR]));
    assign timeout_d  = to_set | (timeout_q & ~(st_wr & pwdata[ST_TO]));
    assign err_clr_d  = st_wr & pwdata[ST_PERR];
    assign irq_d      = (ctrl_q.rxne_en & (fifo_level >= thresh_eff))
                      | (ctrl_q.err_en & (overrun_q | rx_err_i))
                      | (ctrl_q.to_en & timeout_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= CTRL_RST;
            div_q     <= DIV_RST;
            thresh_q  <= LW'(THRESH_RST);
            tmo_q     <= TIMEOUT_RST;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
            err_clr_q <= 1'b0;
            presc_q   <= '0;
            idle_q    <= '0;
        end else begin
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
            err_clr_q <= err_clr_d;
            presc_q   <= presc_d;
            idle_q    <= idle_d;
            if (wr_en) begin
                case (off)
                    OFF_CTRL:    ctrl_q   <= ctrl_t'(pwdata[6:0]);
                    OFF_DIV:     div_q    <= pwdata[15:0];
                    OFF_THRESH:  thresh_q <= pwdata[LW-1:0];
                    OFF_TIMEOUT: tmo_q    <= pwdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_RBR:     rdata[7:0] = fifo_empty ? 8'h00 : fifo_data;
            OFF_CTRL:    rdata[6:0] = ctrl_q;
            OFF_DIV:     rdata[15:0] = div_q;
            OFF_THRESH:  rdata[LW-1:0] = thresh_q;
            OFF_STATUS: begin
                rdata[ST_EMPTY]      = fifo_empty;
                rdata[ST_FULL]       = fifo_full;
                rdata[ST_OVR]        = overrun_q;
                rdata[ST_PERR]       = rx_err_i;
                rdata[ST_TO]         = timeout_q;
                rdata[ST_BUSY]       = rx_busy_i;
                rdata[ST_LEVEL +: LW] = fifo_level;
            end
            OFF_TIMEOUT: rdata[7:0] = tmo_q;
            default: ;
        endcase
    end

    assign prdata          = (rd_en && mapped) ? rdata : 32'd0;
    assign pslverr         = access & ~mapped;
    assign pready          = 1'b1;
    assign cfg_en_o        = ctrl_q.en;
    assign cfg_parity_en_o = ctrl_q.parity_en;
    assign cfg_bits_o      = ctrl_q.bits;
    assign cfg_div_o       = div_q;
    assign rx_ready_o      = ctrl_q.en;
    assign rx_err_clr_o    = err_clr_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_apb_uart_rx_ctrl.sv
// Bench for apb_uart_rx_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        cfg_en_o, cfg_parity_en_o;
    logic [1:0]  cfg_bits_o;
    logic [15:0] cfg_div_o;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0, rx_busy_i = 1'b0, rx_err_i = 1'b0;
    logic        rx_ready_o, rx_err_clr_o, irq_o;

    apb_uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .APB_ADDR_WIDTH(12)) dut (
        .clk(clk), .reset_n(reset_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .cfg_en_o(cfg_en_o), .cfg_parity_en_o(cfg_parity_en_o), .cfg_bits_o(cfg_bits_o),
        .cfg_div_o(cfg_div_o), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .rx_ready_o(rx_ready_o), .rx_busy_i(rx_busy_i), .rx_err_i(rx_err_i),
        .rx_err_clr_o(rx_err_clr_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]    mq[$];
    logic [6:0]    m_ctrl;
    logic [15:0]   m_div;
    logic [LW-1:0] m_th;
    logic [7:0]    m_tmo;
    logic          m_ovr, m_to, m_irq, m_clr;
    int            m_idle;

    logic [7:0]    n_q[$];
    logic [6:0]    n_ctrl;
    logic [15:0]   n_div;
    logic [LW-1:0] n_th;
    logic [7:0]    n_tmo;
    logic          n_ovr, n_to, n_irq, n_clr;
    int            n_idle;

    logic [31:0]   last_prdata;
    logic          last_pslverr;

    task automatic model_reset();
        mq.delete();
        m_ctrl = 7'h0C; m_div = 16'h01B1; m_th = 1; m_tmo = 8'h28;
        m_ovr = 0; m_to = 0; m_irq = 0; m_clr = 0; m_idle = 0;
    endtask

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        r = 32'd0;
        if (!(psel && penable && !pwrite)) return 32'd0;
        case (paddr[4:2])
            3'd0: r = (mq.size() == 0) ? 32'd0 : {24'd0, mq[0]};
            3'd1: r = {25'd0, m_ctrl};
            3'd2: r = {16'd0, m_div};
            3'd3: r = {27'd0, m_th};
            3'd4: r = (32'(mq.size()) << 8) | {26'd0, rx_busy_i, m_to, rx_err_i, m_ovr,
                                               mq.size() == DEPTH, mq.size() == 0};
            3'd5: r = {24'd0, m_tmo};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic compare_outputs();
        chk("prdata", prdata, exp_rd());
        chk("pslverr", pslverr, psel && penable && (paddr[4:2] > 3'd5));
        chk("pready", pready, 1);
        chk("cfg_en", cfg_en_o, m_ctrl[0]);
        chk("cfg_parity", cfg_parity_en_o, m_ctrl[1]);
        chk("cfg_bits", cfg_bits_o, m_ctrl[3:2]);
        chk("cfg_div", cfg_div_o, m_div);
        chk("rx_ready", rx_ready_o, m_ctrl[0]);
        chk("rx_err_clr", rx_err_clr_o, m_clr);
        chk("irq", irq_o, m_irq);
    endtask

    task automatic compute_next();
        logic       wr, rd, pop, flush, pushreq, st_w, ovr_set, to_set, clr;
        logic [2:0] off;
        int         sz, thr, lim;
        off     = paddr[4:2];
        wr      = psel && penable && pwrite;
        rd      = psel && penable && !pwrite;
        pop     = rd && off == 3'd0;
        flush   = wr && off == 3'd1 && pwdata[7];
        pushreq = rx_valid_i && m_ctrl[0];
        st_w    = wr && off == 3'd4;
        sz      = mq.size();
        thr     = (m_th == 0) ? 1 : int'(m_th);
        n_irq   = (m_ctrl[4] && sz >= thr) || (m_ctrl[5] && (m_ovr || rx_err_i)) || (m_ctrl[6] && m_to);
        n_q     = mq;
        ovr_set = 0;
        if (flush) n_q.delete();
        else begin
            if (pop && n_q.size() > 0) void'(n_q.pop_front());
            if (pushreq) begin
                if (n_q.size() < DEPTH) n_q.push_back(rx_data_i);
                else ovr_set = 1;
            end
        end
        n_ctrl = m_ctrl; n_div = m_div; n_th = m_th; n_tmo = m_tmo;
        if (wr && off == 3'd1) n_ctrl = pwdata[6:0];
        if (wr && off == 3'd2) n_div = pwdata[15:0];
        if (wr && off == 3'd3) n_th = pwdata[LW-1:0];
        if (wr && off == 3'd5) n_tmo = pwdata[7:0];
        n_ovr = ovr_set || (m_ovr && !(st_w && pwdata[2]));
        // Timeout fires after (DIV+1)*TIMEOUT uninterrupted idle clocks
        clr    = pushreq || pop || flush || sz == 0 || rx_busy_i;
        lim    = (int'(m_div) + 1) * int'(m_tmo);
        to_set = 0;
        n_idle = m_idle;
        if (clr) n_idle = 0;
        else if (m_tmo != 0 && m_idle < lim) begin
            n_idle = m_idle + 1;
            if (n_idle == lim) to_set = 1;
        end
        n_to  = to_set || (m_to && !(st_w && pwdata[4]));
        n_clr = st_w && pwdata[3];
    endtask

    task automatic commit();
        mq = n_q; m_ctrl = n_ctrl; m_div = n_div; m_th = n_th; m_tmo = n_tmo;
        m_ovr = n_ovr; m_to = n_to; m_irq = n_irq; m_clr = n_clr; m_idle = n_idle;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        last_prdata  = prdata;
        last_pslverr = pslverr;
        compute_next();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1; psel = 1; penable = 0;
        cycle();
        penable = 1;
        cycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
        paddr = a; pwrite = 0; psel = 1; penable = 0;
        cycle();
        penable = 1;
        cycle();
        d = last_prdata;
        psel = 0; penable = 0;
    endtask

    task automatic push(input logic [7:0] c);
        rx_valid_i = 1; rx_data_i = c;
        cycle();
        rx_valid_i = 0;
    endtask

    task automatic rnd_rx();
        rx_valid_i = ($urandom_range(0, 99) < 45);
        rx_data_i  = 8'($urandom);
        rx_busy_i  = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) rx_err_i = ~rx_err_i;
    endtask

    task automatic rnd_apb(input logic [11:0] a, input logic [31:0] d, input logic w);
        paddr = a; pwdata = d; pwrite = w; psel = 1; penable = 0;
        rnd_rx(); cycle();
        penable = 1;
        rnd_rx(); cycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        #1 reset_n = 0;
        model_reset();
        #20;
        chk("rst_prdata", prdata, 0);
        chk("rst_pready", pready, 1);
        chk("rst_cfg_bits", cfg_bits_o, 2'b11);
        chk("rst_cfg_div", cfg_div_o, 16'h01B1);
        chk("rst_rx_ready", rx_ready_o, 0);
        chk("rst_irq", irq_o, 0);
        @(posedge clk); #1 reset_n = 1;

        // Configuration writes and readback
        apb_wr(12'h004, 32'h03);
        chk("ctrl_cfg_en", cfg_en_o, 1);
        chk("ctrl_cfg_par", cfg_parity_en_o, 1);
        chk("ctrl_cfg_bits", cfg_bits_o, 0);
        apb_wr(12'h008, 32'h10);
        chk("div_cfg", cfg_div_o, 16'h0010);
        apb_rd(12'h004, d); chk("ctrl_rd", d, 32'h3);
        apb_rd(12'h008, d); chk("div_rd", d, 32'h10);

        // Three characters in, three out, then an empty read
        push(8'h41); push(8'h42); push(8'h43);
        apb_rd(12'h010, d); chk("status_lvl3", d, 32'h300);
        apb_rd(12'h000, d); chk("rbr_0", d, 32'h41);
        apb_rd(12'h000, d); chk("rbr_1", d, 32'h42);
        apb_rd(12'h000, d); chk("rbr_2", d, 32'h43);
        apb_rd(12'h000, d); chk("rbr_empty", d, 32'h0);
        apb_rd(12'h010, d); chk("status_empty", d, 32'h1);

        // Overflow, W1C, simultaneous push/pop at full, flush
        for (int i = 0; i <= DEPTH; i++) push(8'h50 + 8'(i));
        apb_rd(12'h010, d); chk("status_ovr", d, 32'h1006);
        apb_wr(12'h010, 32'h4);
        apb_rd(12'h010, d); chk("status_ovr_clr", d, 32'h1002);
        paddr = 12'h000; pwrite = 0; psel = 1; penable = 0;
        cycle();
        penable = 1; rx_valid_i = 1; rx_data_i = 8'hEE;
        cycle();
        chk("full_pushpop_rd", last_prdata, 32'h50);
        psel = 0; penable = 0; rx_valid_i = 0;
        apb_rd(12'h010, d); chk("full_pushpop_lvl", d, 32'h1002);
        apb_wr(12'h004, 32'h83);
        apb_rd(12'h010, d); chk("flush_status", d, 32'h1);

        // Level threshold interrupt
        apb_wr(12'h00C, 32'h4);
        apb_wr(12'h004, 32'h13);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        chk("thr_irq_lag", irq_o, 0);
        cycle();
        chk("thr_irq_rise", irq_o, 1);
        apb_rd(12'h000, d);
        chk("thr_irq_hold", irq_o, 1);
        cycle();
        chk("thr_irq_fall", irq_o, 0);
        apb_wr(12'h004, 32'h83);

        // Idle timeout: DIV=3, TIMEOUT=2 -> 8 idle clocks
        apb_wr(12'h008, 32'h3);
        apb_wr(12'h014, 32'h2);
        apb_wr(12'h004, 32'h41);
        push(8'h77);
        repeat (8) cycle();
        chk("to_irq_lag", irq_o, 0);
        cycle();
        chk("to_irq_rise", irq_o, 1);
        apb_rd(12'h010, d); chk("to_status", d, 32'h110);
        apb_rd(12'h000, d); chk("to_rbr", d, 32'h77);
        apb_wr(12'h010, 32'h10);
        apb_rd(12'h010, d); chk("to_w1c", d, 32'h1);

        // Parity error interrupt, clear pulse, unmapped access
        rx_err_i = 1;
        apb_wr(12'h004, 32'h21);
        cycle();
        chk("err_irq", irq_o, 1);
        apb_wr(12'h010, 32'h8);
        chk("err_clr_pulse", rx_err_clr_o, 1);
        cycle();
        chk("err_clr_end", rx_err_clr_o, 0);
        rx_err_i = 0;
        apb_rd(12'h018, d);
        chk("unmapped_slverr", last_pslverr, 1);
        chk("unmapped_rdata", d, 0);
        apb_wr(12'h01C, 32'hFFFF_FFFF);

        // Randomized traffic
        apb_wr(12'h004, 32'h83);
        apb_wr(12'h008, 32'h1);
        apb_wr(12'h014, 32'h3);
        apb_wr(12'h004, 32'h71);
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rnd_apb(12'h000, 32'h0, 0);
                3:       rnd_apb(12'h010, 32'h0, 0);
                4:       rnd_apb(12'h010, $urandom & 32'h1C, 1);
                5:       begin rnd_rx(); cycle(); rnd_rx(); cycle(); end
                6:       rnd_apb(12'h00C, 32'($urandom_range(0, 17)), 1);
                7:       rnd_apb(12'h004, 32'h01 | ($urandom & 32'h7E) |
                                 (($urandom_range(0, 7) == 0) ? 32'h80 : 32'h0), 1);
                8:       rnd_apb(12'(($urandom_range(0, 7)) << 2), 32'h0, 0);
                default: begin
                    rx_valid_i = 0; rx_busy_i = 0;
                    repeat (6) cycle();
                end
            endcase
        end
        rx_valid_i = 0; rx_busy_i = 0; rx_err_i = 0;
        cycle();

        // Asynchronous reset in the middle of an access with a character arriving
        apb_wr(12'h004, 32'h71);
        push(8'hA5);
        rx_valid_i = 1; rx_data_i = 8'h5A;
        paddr = 12'h010; pwrite = 1; pwdata = 32'h1C; psel = 1; penable = 1;
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("mid_rst_cfg_en", cfg_en_o, 0);
        chk("mid_rst_cfg_div", cfg_div_o, 16'h01B1);
        chk("mid_rst_cfg_bits", cfg_bits_o, 2'b11);
        chk("mid_rst_irq", irq_o, 0);
        chk("mid_rst_errclr", rx_err_clr_o, 0);
        chk("mid_rst_rx_ready", rx_ready_o, 0);
        psel = 0; penable = 0; pwrite = 0; rx_valid_i = 0;
        @(posedge clk); #1 reset_n = 1;
        apb_rd(12'h010, d); chk("post_rst_status", d, 32'h1);
        apb_rd(12'h004, d); chk("post_rst_ctrl", d, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
